// File: rtl/sii_irq_debounce_pkg.sv
// Shared encodings and helpers for the interrupt/button debounce block.
// Holds the edge_sel codes, the debounce FSM state type and small decode helpers.
`ifndef SII_IRQ_DEBOUNCE_PKG_SV
`define SII_IRQ_DEBOUNCE_PKG_SV

package sii_irq_debounce_pkg;

  localparam logic [1:0] EDGE_RISE  = 2'b00;
  localparam logic [1:0] EDGE_FALL  = 2'b01;
  localparam logic [1:0] EDGE_BOTH  = 2'b10;
  localparam logic [1:0] EDGE_LEVEL = 2'b11;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } db_state_e;

  function automatic logic state_level(input db_state_e s);
    return (s == IDLE_HI) || (s == CHK_LO);
  endfunction

  function automatic logic edge_select(input logic [1:0] sel,
                                       input logic       rise,
                                       input logic       fall);
    logic p;
    unique case (sel)
      EDGE_RISE: p = rise;
      EDGE_FALL: p = fall;
      EDGE_BOTH: p = rise | fall;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

`endif

// File: rtl/sii_debounce_core.sv
// Consecutive-sample debounce filter: four-state FSM plus run-length counter.
// rise/fall are registered so they coincide with the first cycle of the new level.
module sii_debounce_core
  import sii_irq_debounce_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_sync,
  output logic level_db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (in_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE_HI;
            rise_d  = 1'b1;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!in_sync) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!in_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE_LO;
            fall_d  = 1'b1;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (in_sync) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_db = state_level(state_q);
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/sii_irq_debounce.sv
// Debounced interrupt pin: edge/level qualification plus sticky pending and overrun
// flags, cleared by a one-cycle CSR pulse.
module sii_irq_debounce
  import sii_irq_debounce_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_sync,
  input  logic       en,
  input  logic [1:0] edge_sel,
  input  logic       irq_clr,
  output logic       level_db,
  output logic       edge_pulse,
  output logic       irq_pending,
  output logic       irq_overrun
);

  logic rise, fall;
  logic level_mode, event_w;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;

  sii_debounce_core #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_sync (in_sync),
    .level_db(level_db),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    level_mode = (edge_sel == EDGE_LEVEL);
    edge_pulse = edge_select(edge_sel, rise, fall);
    // In level mode the clear wins for its own cycle, so pending drops for one
    // cycle and re-asserts while level_db stays high; edge modes let set win.
    event_w    = level_mode ? (level_db & ~irq_clr) : edge_pulse;
    pending_d  = (pending_q & ~irq_clr) | (event_w & en);
    overrun_d  = (overrun_q & ~irq_clr)
               | (event_w & en & pending_q & ~irq_clr & ~level_mode);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq_pending = pending_q;
  assign irq_overrun = overrun_q;

endmodule

// File: tb/tb_sii_irq_debounce.sv
// Bench for sii_irq_debounce with DEBOUNCE_CYCLES=4: directed scenarios followed by
// random traffic, all checked against a run-length reference model.
module tb_sii_irq_debounce;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n, in_sync, en, irq_clr;
  logic [1:0] edge_sel;
  logic       level_db, edge_pulse, irq_pending, irq_overrun;

  always #5 clk = ~clk;

  sii_irq_debounce #(
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_sync    (in_sync),
    .en         (en),
    .edge_sel   (edge_sel),
    .irq_clr    (irq_clr),
    .level_db   (level_db),
    .edge_pulse (edge_pulse),
    .irq_pending(irq_pending),
    .irq_overrun(irq_overrun)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference model: filtered level, length of the current run of samples that
  // disagree with it, last-cycle flip direction, and the sticky flags.
  bit m_lvl, m_rose, m_fell, m_pend, m_ovr;
  int m_run;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %b expected %b at %0t", phase, tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pulse();
    case (edge_sel)
      2'd0:    return m_rose;
      2'd1:    return m_fell;
      2'd2:    return m_rose || m_fell;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clock();
    bit ev, pend_old;
    if (!rst_n) begin
      m_lvl = 0; m_run = 0; m_rose = 0; m_fell = 0; m_pend = 0; m_ovr = 0;
      return;
    end
    if (edge_sel == 2'd3) ev = m_lvl && !irq_clr;
    else                  ev = m_pulse();
    pend_old = m_pend;
    m_pend = (m_pend && !irq_clr) || (ev && en);
    m_ovr  = (m_ovr && !irq_clr) ||
             (ev && en && pend_old && !irq_clr && edge_sel != 2'd3);
    m_rose = 0;
    m_fell = 0;
    if (in_sync != m_lvl) begin
      m_run++;
      if (m_run == N) begin
        m_lvl  = !m_lvl;
        m_run  = 0;
        m_rose = m_lvl;
        m_fell = !m_lvl;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("level_db",    level_db,    m_lvl);
    check("edge_pulse",  edge_pulse,  m_pulse());
    check("irq_pending", irq_pending, m_pend);
    check("irq_overrun", irq_overrun, m_ovr);
  endtask

  task automatic hold(input logic v, input int n);
    in_sync = v;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_clr();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  initial begin
    int  hold_n;
    bit  seen;
    rst_n = 1'b0; in_sync = 1'b0; en = 1'b1; edge_sel = 2'd0; irq_clr = 1'b0;
    m_lvl = 0; m_run = 0; m_rose = 0; m_fell = 0; m_pend = 0; m_ovr = 0;

    phase = "reset";
    step(); step();
    check("rst_level", level_db, 1'b0);
    check("rst_pend",  irq_pending, 1'b0);

    phase = "rise_after_reset";
    rst_n = 1'b1;
    hold(1'b1, 3);
    check("lvl_before_4th", level_db, 1'b0);
    step();
    check("lvl_on_4th",   level_db,   1'b1);
    check("pulse_on_4th", edge_pulse, 1'b1);
    check("pend_on_4th",  irq_pending, 1'b0);
    step();
    check("pend_next",  irq_pending, 1'b1);
    check("pulse_next", edge_pulse,  1'b0);

    phase = "glitch";
    rst_n = 1'b0; in_sync = 1'b0; step(); rst_n = 1'b1;
    for (int r = 0; r < 10; r++) begin
      hold(1'b1, 3);
      hold(1'b0, 1);
    end
    check("glitch_lvl",  level_db,    1'b0);
    check("glitch_pend", irq_pending, 1'b0);

    phase = "fall_only";
    edge_sel = 2'd1;
    hold(1'b1, 5);
    check("fall_only_no_rise", irq_pending, 1'b0);
    hold(1'b0, 5);
    check("fall_only_pend", irq_pending, 1'b1);

    phase = "both";
    edge_sel = 2'd2;
    pulse_clr();
    hold(1'b1, 5);
    pulse_clr();
    hold(1'b0, 5);
    check("both_fall_pend", irq_pending, 1'b1);

    phase = "overrun";
    edge_sel = 2'd0;
    pulse_clr();
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    check("ovr_set",  irq_overrun, 1'b1);
    pulse_clr();
    check("clr_pend", irq_pending, 1'b0);
    check("clr_ovr",  irq_overrun, 1'b0);

    phase = "clr_with_edge";
    edge_sel = 2'd2;
    hold(1'b0, 5);
    check("pend_before", irq_pending, 1'b1);
    in_sync = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = edge_pulse;
    end
    check("edge_seen", seen, 1'b1);
    pulse_clr();
    check("coinc_pend", irq_pending, 1'b1);
    check("coinc_ovr",  irq_overrun, 1'b0);

    phase = "level";
    edge_sel = 2'd3;
    hold(1'b1, 3);
    check("lvl_pend", irq_pending, 1'b1);
    pulse_clr();
    check("lvl_clr_drop", irq_pending, 1'b0);
    step();
    check("lvl_reassert", irq_pending, 1'b1);
    check("lvl_no_ovr",   irq_overrun, 1'b0);
    en = 1'b0;
    pulse_clr();
    step();
    check("en0_pend", irq_pending, 1'b0);
    en = 1'b1;

    phase = "reset_mid_count";
    edge_sel = 2'd0;
    hold(1'b0, 5);
    pulse_clr();
    hold(1'b1, 2);
    rst_n = 1'b0;
    step();
    check("mid_lvl",   level_db,    1'b0);
    check("mid_pulse", edge_pulse,  1'b0);
    check("mid_pend",  irq_pending, 1'b0);
    check("mid_ovr",   irq_overrun, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 3);
    check("mid_lvl3", level_db, 1'b0);
    step();
    check("mid_lvl4", level_db, 1'b1);

    phase = "random";
    hold_n = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_n == 0) begin
        in_sync = ~in_sync;
        hold_n  = $urandom_range(1, 7);
      end
      hold_n--;
      en      = ($urandom_range(0, 9) != 0);
      irq_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) edge_sel = 2'($urandom_range(0, 3));
      rst_n   = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
